mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multicycle control unit that sequences the shared MIPS datapath built from the team's register file, adder, sign-extend, shift-left-2, enabled flops, and 2/3/4-input muxes. It uses one ALU and one unified instruction/data memory. It decodes the opcode and funct of the latched instruction and walks a Moore FSM that drives every mux select, register enable, and write strobe. Memory states stall on a ready handshake.

## Interface
Parameters:
- none (all encodings are fixed constants in the package)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces FETCH
- op  input  6  instruction[31:26] from the instruction register
- funct  input  6  instruction[5:0]
- zero  input  1  ALU zero flag
- memready  input  1  memory has completed the current access this cycle
- pcen  output  1  PC flop enable
- irwrite  output  1  instruction register enable
- memwrite  output  1  memory write request
- regwrite  output  1  regfile we3
- iord  output  1  address mux: 0 = PC, 1 = ALUOut
- memtoreg  output  1  regfile wd3 mux: 0 = ALUOut, 1 = Data
- regdst  output  1  wa3 mux: 0 = rt, 1 = rd
- alusrca  output  1  0 = PC, 1 = A register
- alusrcb  output  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  output  1  one-cycle pulse on an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH drives iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00.
  - irwrite = pcwrite = memready.
  - Stay in FETCH while memready=0; go to DECODE when memready=1.
- DECODE drives alusrca=0, alusrcb=11, aluop=ADD to precompute the branch target. Next state by op:
  - 100011 / 101011 (lw / sw) → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - any other op → FETCH, with illegal=1 in this DECODE cycle
- MEMADR: alusrca=1, alusrcb=10, ADD. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold until memready, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next is FETCH.
- MEMWR: iord=1, memwrite=1 held level. Hold until memready, then go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=FUNCT. Next is RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next is FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, branch=1. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ADD. Next is ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next is FETCH.
- JEX: pcsrc=10, pcwrite=1. Next is FETCH.
- pcen = pcwrite | (branch & zero).
- ALU decode:
  - aluop ADD → 010; aluop SUB → 110.
  - aluop FUNCT maps funct 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Unknown funct → 010; it raises no flag.
- Every output not listed for a state is 0.

## Timing
- State register updates on posedge clk. reset is asynchronous and takes priority.
- All outputs are combinational from state, except:
  - pcen, irwrite depend on memready, zero.
  - alucontrol depends on funct in RTYPEEX.
  - illegal depends on op in DECODE.
- While reset=1, pcen, irwrite, memwrite, regwrite, illegal are all 0 regardless of memready; other outputs take their FETCH values.
- Reset mid-instruction abandons the instruction. The first fetch after reset deassertion starts on the next edge.
- Latency with memready tied to 1:
  - j and beq: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
- Each memready=0 cycle in FETCH, MEMRD, or MEMWR adds one cycle. Outputs stay stable while stalled.
- In MEMWR, memwrite remains asserted through the cycle in which memready=1 and then drops.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum
  - opcode and funct constants
  - the alusrcb, pcsrc, aluop, and alucontrol encodings
- Sub-module mc_aludec: combinational decode (aluop, funct) → alucontrol.
- The FSM and output logic live in mips_mc_controller.

## Test plan
- Reset asserted mid-MEMRD → state is FETCH immediately (asynchronous). While reset=1: pcen=0, irwrite=0, regwrite=0, memwrite=0, alusrcb=01.
- lw (op 100011), memready=1 → 5 cycles. iord=1 in MEMRD. MEMWB has regwrite=1, memtoreg=1, regdst=0. pcen=1 only in the FETCH cycle.
- sw with memready low for 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles, then FETCH. regwrite stays 0 throughout.
- beq with zero=1 → pcen=1 and pcsrc=01 in BEQEX. With zero=0 → pcen=0 in BEQEX.
- R-type sweep, funct 100000/100010/100100/100101/101010 → alucontrol 010/110/000/001/111 in RTYPEEX. RTYPEWB has regdst=1, regwrite=1.
- op 111111 → illegal=1 for exactly one cycle in DECODE, then FETCH. No regwrite or memwrite is asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode, funct and control encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - combinational (aluop, funct) to alucontrol decode
module mc_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        // unrecognised funct quietly falls back to add
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - Moore FSM sequencing the shared multicycle MIPS datapath
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       pcwrite, branch;
  logic       irwrite_d, memwrite_d, regwrite_d, illegal_d;
  logic [1:0] aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_d  = 1'b0;
    memwrite_d = 1'b0;
    regwrite_d = 1'b0;
    illegal_d  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALURES;
    aluop      = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        irwrite_d = memready;
        pcwrite   = memready;
        if (memready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (memready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_d = 1'b1;
        if (memready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // strobes are masked during reset so a ready memory cannot advance PC or IR
  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign irwrite  = ~reset & irwrite_d;
  assign memwrite = ~reset & memwrite_d;
  assign regwrite = ~reset & regwrite_d;
  assign illegal  = ~reset & illegal_d;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed self-checking bench for mips_mc_controller
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [15:0] ctl;

  int total = 0;
  int bad   = 0;

  mips_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign ctl = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};

  function automatic logic [15:0] v(input logic pe, irw, mw, rw, io, m2r, rd, asa,
                                    input logic [1:0] asb, pcs, input logic [2:0] aluc,
                                    input logic ill);
    return {pe, irw, mw, rw, io, m2r, rd, asa, asb, pcs, aluc, ill};
  endfunction

  function automatic logic [15:0] e_fetch(input logic mr);
    return v(mr, mr, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] e_decode(input logic ill);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, ill);
  endfunction
  function automatic logic [15:0] e_rex(input logic [2:0] aluc);
    return v(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, aluc, 0);
  endfunction
  function automatic logic [15:0] e_beq(input logic z);
    return v(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
  endfunction

  logic [15:0] e_memadr, e_memrd, e_memwb, e_memwr, e_rwb, e_aex, e_awb, e_jex, e_rst;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // inputs are applied just after a falling edge, checked 1ns later, and consumed at the next rising edge
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [15:0] exp);
    memready = mr;
    zero     = z;
    #1;
    chk(tag, ctl, exp);
    @(negedge clk);
  endtask

  logic [5:0] fn_tab [0:5];
  logic [2:0] ac_tab [0:5];

  initial begin
    e_memadr = v(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    e_memrd  = v(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    e_memwb  = v(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    e_memwr  = v(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    e_rwb    = v(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
    e_aex    = v(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    e_awb    = v(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    e_jex    = v(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);
    e_rst    = e_fetch(1'b0);
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
    ac_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

    reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0; memready = 1'b1;
    @(negedge clk);
    #1 chk("reset_hold", ctl, e_rst);
    reset = 1'b0;

    // lw, memready high: five cycles
    cyc("lw_fetch",  1, 0, e_fetch(1));
    cyc("lw_decode", 1, 0, e_decode(0));
    cyc("lw_memadr", 1, 0, e_memadr);
    cyc("lw_memrd",  1, 0, e_memrd);
    cyc("lw_memwb",  1, 0, e_memwb);

    // sw stalled three cycles in MEMWR
    op = 6'b101011;
    cyc("sw_fetch",  1, 0, e_fetch(1));
    cyc("sw_decode", 1, 0, e_decode(0));
    cyc("sw_memadr", 1, 0, e_memadr);
    cyc("sw_memwr0", 0, 0, e_memwr);
    cyc("sw_memwr1", 0, 0, e_memwr);
    cyc("sw_memwr2", 0, 0, e_memwr);
    cyc("sw_memwr3", 1, 0, e_memwr);
    cyc("fetch_stall", 0, 0, e_fetch(0));

    // reset asserted mid-MEMRD takes effect without a clock edge
    op = 6'b100011;
    cyc("lw2_fetch",  1, 0, e_fetch(1));
    cyc("lw2_decode", 1, 0, e_decode(0));
    cyc("lw2_memadr", 1, 0, e_memadr);
    cyc("lw2_memrd_stall", 0, 0, e_memrd);
    memready = 1'b1;
    reset    = 1'b1;
    #1 chk("reset_async", ctl, e_rst);
    @(negedge clk);
    #1 chk("reset_hold2", ctl, e_rst);
    reset = 1'b0;

    // beq taken and not taken
    op = 6'b000100;
    cyc("beq1_fetch",  1, 1, e_fetch(1));
    cyc("beq1_decode", 1, 1, e_decode(0));
    cyc("beq1_ex",     1, 1, e_beq(1));
    cyc("beq0_fetch",  1, 0, e_fetch(1));
    cyc("beq0_decode", 1, 0, e_decode(0));
    cyc("beq0_ex",     1, 0, e_beq(0));

    // R-type funct sweep, last entry is an unknown funct
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      cyc($sformatf("rt%0d_fetch", i),  1, 0, e_fetch(1));
      cyc($sformatf("rt%0d_decode", i), 1, 0, e_decode(0));
      cyc($sformatf("rt%0d_ex", i),     1, 0, e_rex(ac_tab[i]));
      cyc($sformatf("rt%0d_wb", i),     1, 0, e_rwb);
    end

    op = 6'b001000;
    cyc("addi_fetch",  1, 0, e_fetch(1));
    cyc("addi_decode", 1, 0, e_decode(0));
    cyc("addi_ex",     1, 0, e_aex);
    cyc("addi_wb",     1, 0, e_awb);

    op = 6'b000010;
    cyc("j_fetch",  1, 0, e_fetch(1));
    cyc("j_decode", 1, 0, e_decode(0));
    cyc("j_ex",     1, 0, e_jex);

    // unsupported opcode: one-cycle illegal pulse, back to FETCH
    op = 6'b111111;
    cyc("ill_fetch",  1, 0, e_fetch(1));
    cyc("ill_decode", 1, 0, e_decode(1));
    cyc("ill_after",  0, 0, e_fetch(0));
    cyc("ill_after2", 1, 0, e_fetch(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
